// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared state encoding and width helpers for the line memory.
package line_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } line_mem_state_t;

    localparam int unsigned WORD_BITS = 32;

    // Width of one whole line in bits.
    function automatic int unsigned line_bits(input int unsigned words);
        return words * WORD_BITS;
    endfunction

    // Width of the line index; kept at least 1 so a single-line array still elaborates.
    function automatic int unsigned idx_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Position of the line index inside a byte address.
    function automatic int unsigned off_bits(input int unsigned words);
        return $clog2(words) + 2;
    endfunction

endpackage

// File: rtl/line_mem_array.sv
// line_mem_array: line-wide storage, synchronous write, combinational read, never reset.
module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter int unsigned DEPTH_LINES    = 64
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [idx_bits(DEPTH_LINES)-1:0]      waddr,
    input  logic [line_bits(WORDS_PER_LINE)-1:0]  wdata,
    input  logic [idx_bits(DEPTH_LINES)-1:0]      raddr,
    output logic [line_bits(WORDS_PER_LINE)-1:0]  rdata
);

    localparam int unsigned LB = line_bits(WORDS_PER_LINE);

    logic [LB-1:0] mem [DEPTH_LINES];

    // Whole-line write on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/line_mem.sv
// line_mem: multi-cycle line-granular backing memory with req/ready/done handshake.
// Optional macro LINE_MEM_POSTED_WRITE_EN: writes complete in the cycle after accept
// regardless of LAT; reads always take LAT.
module line_mem
    import line_mem_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter int unsigned DEPTH_LINES    = 64,
    parameter int unsigned LAT            = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  req,
    input  logic                                  we,
    input  logic [31:0]                           addr,
    input  logic [line_bits(WORDS_PER_LINE)-1:0]  wdata,
    output logic                                  ready,
    output logic                                  done,
    output logic [line_bits(WORDS_PER_LINE)-1:0]  rdata
);

    localparam int unsigned LB  = line_bits(WORDS_PER_LINE);
    localparam int unsigned IW  = idx_bits(DEPTH_LINES);
    localparam int unsigned OFF = off_bits(WORDS_PER_LINE);
    localparam int unsigned CW  = $clog2(LAT + 1);

    line_mem_state_t state;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic [IW-1:0]   idx_q;

    logic            accept;
    logic            direct;
    logic            wr_en;
    logic [IW-1:0]   addr_idx;
    logic [IW-1:0]   rd_idx;
    logic [LB-1:0]   rd_line;
    logic            unused_addr;

    // Offset bits and upper address bits are don't-care; addresses wrap.
    assign addr_idx    = addr[OFF +: IW];
    assign unused_addr = ^addr;

    assign accept = req & ready;
    // Reset wins over a simultaneous request, including its array write.
    assign wr_en  = accept & we & ~reset;

`ifdef LINE_MEM_POSTED_WRITE_EN
    assign direct = (LAT == 1) || we;
`else
    assign direct = (LAT == 1);
`endif

    // Direct-to-RESP reads sample the incoming index; BUSY completions use the captured one.
    assign rd_idx = (state == BUSY) ? idx_q : addr_idx;

    line_mem_array #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .DEPTH_LINES    (DEPTH_LINES)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (addr_idx),
        .wdata (wdata),
        .raddr (rd_idx),
        .rdata (rd_line)
    );

    // Control FSM with latency counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            we_q  <= 1'b0;
            idx_q <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            rdata <= '0;
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        we_q  <= we;
                        idx_q <= addr_idx;
                        if (direct) begin
                            state <= RESP;
                            cnt   <= '0;
                            ready <= 1'b1;
                            done  <= 1'b1;
                            if (!we) begin
                                rdata <= rd_line;
                            end
                        end else begin
                            state <= BUSY;
                            cnt   <= CW'(LAT - 1);
                            ready <= 1'b0;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                BUSY: begin
                    // Leave when the decrement would reach zero, so done lands LAT cycles out.
                    if (cnt <= CW'(1)) begin
                        state <= RESP;
                        cnt   <= '0;
                        ready <= 1'b1;
                        done  <= 1'b1;
                        if (!we_q) begin
                            rdata <= rd_line;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
